// File: rtl/sv32_page_table_walker_pkg.sv
// Shared RV32 translation types: Sv32 PTE layout, satp CSR, access kinds and
// the walker's state encoding.
package sv32_page_table_walker_pkg;

    localparam int VADDR_W = 32;
    localparam int PADDR_W = 34;
    localparam int PTE_W   = 32;
    localparam int PPN_W   = 22;
    localparam int VPN_W   = 20;

    typedef logic [PPN_W-1:0] physical_page_number_t;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } PageTableEntry;

    typedef struct packed {
        logic                  mode;
        logic [8:0]            asid;
        physical_page_number_t ppn;
    } csr_satp_t;

    typedef enum logic [1:0] {
        ACC_READ  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_EXEC  = 2'd2
    } MemAccessType;

    typedef enum logic [2:0] {
        IDLE,
        L1_READ,
        L0_READ,
        UPDATE,
        DONE
    } PtwState;

endpackage

// File: rtl/sv32_page_table_walker_if.sv
// Request, response and memory-port bundle of the Sv32 walker.
// master = requester/memory side, slave = the walker itself.
interface sv32_page_table_walker_if;
    import sv32_page_table_walker_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [VPN_W-1:0]      req_vpn;
    logic [1:0]            req_access;
    logic                  req_user;
    csr_satp_t             csr_satp;
    logic                  csr_mxr;
    logic                  csr_sum;

    logic                  resp_valid;
    logic                  resp_fault;
    physical_page_number_t resp_ppn;
    logic                  resp_superpage;
    logic [PTE_W-1:0]      resp_pte;

    logic                  mem_req;
    logic                  mem_write;
    logic [PADDR_W-1:0]    mem_addr;
    logic [PTE_W-1:0]      mem_wdata;
    logic [PTE_W-1:0]      mem_rdata;
    logic                  mem_done;

    modport master (
        output req_valid, req_vpn, req_access, req_user, csr_satp, csr_mxr, csr_sum,
        output mem_rdata, mem_done,
        input  req_ready, resp_valid, resp_fault, resp_ppn, resp_superpage, resp_pte,
        input  mem_req, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_vpn, req_access, req_user, csr_satp, csr_mxr, csr_sum,
        input  mem_rdata, mem_done,
        output req_ready, resp_valid, resp_fault, resp_ppn, resp_superpage, resp_pte,
        output mem_req, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sv32_page_table_walker_pte.sv
// Combinational Sv32 PTE classifier: validity, leaf/level rules, permissions
// and the Accessed/Dirty update value.
module sv32_pte_checker
    import sv32_page_table_walker_pkg::*;
(
    input  PageTableEntry pte,
    input  logic          level,
    input  MemAccessType  access,
    input  logic          user,
    input  logic          mxr,
    input  logic          sum,
    output logic          is_leaf,
    output logic          fault,
    output logic          need_update,
    output PageTableEntry updated_pte
);

    logic invalid;
    logic misaligned;
    logic perm_ok;

    always_comb begin
        invalid    = !pte.v || (pte.w && !pte.r);
        is_leaf    = pte.r || pte.x;
        misaligned = level && (pte.ppn0 != '0);

        case (access)
            ACC_READ:  perm_ok = pte.r || (mxr && pte.x);
            ACC_WRITE: perm_ok = pte.w;
            ACC_EXEC:  perm_ok = pte.x;
            default:   perm_ok = 1'b0;
        endcase

        // Supervisor may touch user pages only for data, and only with SUM set.
        if (user) begin
            perm_ok = perm_ok && pte.u;
        end else if (pte.u) begin
            perm_ok = perm_ok && sum && (access != ACC_EXEC);
        end

        // A non-leaf is only legal at level 1; at level 0 it ends the walk.
        fault = invalid || (is_leaf ? (misaligned || !perm_ok) : !level);

        need_update   = !pte.a || ((access == ACC_WRITE) && !pte.d);
        updated_pte   = pte;
        updated_pte.a = 1'b1;
        if (access == ACC_WRITE) begin
            updated_pte.d = 1'b1;
        end
    end

endmodule

// File: rtl/sv32_page_table_walker.sv
// Sv32 hardware page-table walker: one or two PTE reads, permission check,
// optional A/D write-back, then a single-cycle response.
module sv32_page_table_walker
    import sv32_page_table_walker_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    sv32_page_table_walker_if.slave  bus
);

    PtwState               state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic [9:0]            vpn0_q, vpn0_d;
    MemAccessType          access_q, access_d;
    logic                  user_q, user_d;
    logic                  mxr_q, mxr_d;
    logic                  sum_q, sum_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_write_q, mem_write_d;
    logic [PADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [PTE_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_fault_q, resp_fault_d;
    physical_page_number_t resp_ppn_q, resp_ppn_d;
    logic                  resp_superpage_q, resp_superpage_d;
    logic [PTE_W-1:0]      resp_pte_q, resp_pte_d;

    PageTableEntry rd_pte;
    PageTableEntry chk_updated;
    logic          at_level1;
    logic          chk_leaf;
    logic          chk_fault;
    logic          chk_need_update;

    assign rd_pte    = PageTableEntry'(bus.mem_rdata);
    assign at_level1 = (state_q == L1_READ);

    sv32_pte_checker u_checker (
        .pte         (rd_pte),
        .level       (at_level1),
        .access      (access_q),
        .user        (user_q),
        .mxr         (mxr_q),
        .sum         (sum_q),
        .is_leaf     (chk_leaf),
        .fault       (chk_fault),
        .need_update (chk_need_update),
        .updated_pte (chk_updated)
    );

    always_comb begin
        state_d          = state_q;
        req_ready_d      = req_ready_q;
        vpn0_d           = vpn0_q;
        access_d         = access_q;
        user_d           = user_q;
        mxr_d            = mxr_q;
        sum_d            = sum_q;
        mem_req_d        = mem_req_q;
        mem_write_d      = mem_write_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        resp_valid_d     = 1'b0;
        resp_fault_d     = resp_fault_q;
        resp_ppn_d       = resp_ppn_q;
        resp_superpage_d = resp_superpage_q;
        resp_pte_d       = resp_pte_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d     = L1_READ;
                    req_ready_d = 1'b0;
                    vpn0_d      = bus.req_vpn[9:0];
                    access_d    = MemAccessType'(bus.req_access);
                    user_d      = bus.req_user;
                    mxr_d       = bus.csr_mxr;
                    sum_d       = bus.csr_sum;
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {bus.csr_satp.ppn, bus.req_vpn[19:10], 2'b00};
                end
            end
            L1_READ, L0_READ: begin
                if (bus.mem_done) begin
                    if (chk_fault) begin
                        state_d          = DONE;
                        mem_req_d        = 1'b0;
                        resp_valid_d     = 1'b1;
                        resp_fault_d     = 1'b1;
                        resp_ppn_d       = '0;
                        resp_superpage_d = 1'b0;
                        resp_pte_d       = rd_pte;
                    end else if (!chk_leaf) begin
                        state_d    = L0_READ;
                        mem_addr_d = {rd_pte.ppn1, rd_pte.ppn0, vpn0_q, 2'b00};
                    end else begin
                        resp_fault_d     = 1'b0;
                        resp_superpage_d = at_level1;
                        resp_ppn_d       = at_level1 ? {rd_pte.ppn1, vpn0_q}
                                                     : {rd_pte.ppn1, rd_pte.ppn0};
                        // Write-back reuses the leaf address already on mem_addr.
                        if (chk_need_update) begin
                            state_d     = UPDATE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = chk_updated;
                            resp_pte_d  = chk_updated;
                        end else begin
                            state_d      = DONE;
                            mem_req_d    = 1'b0;
                            resp_valid_d = 1'b1;
                            resp_pte_d   = rd_pte;
                        end
                    end
                end
            end
            UPDATE: begin
                if (bus.mem_done) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    mem_write_d  = 1'b0;
                    resp_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            req_ready_q      <= 1'b1;
            vpn0_q           <= '0;
            access_q         <= ACC_READ;
            user_q           <= 1'b0;
            mxr_q            <= 1'b0;
            sum_q            <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            resp_valid_q     <= 1'b0;
            resp_fault_q     <= 1'b0;
            resp_ppn_q       <= '0;
            resp_superpage_q <= 1'b0;
            resp_pte_q       <= '0;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            vpn0_q           <= vpn0_d;
            access_q         <= access_d;
            user_q           <= user_d;
            mxr_q            <= mxr_d;
            sum_q            <= sum_d;
            mem_req_q        <= mem_req_d;
            mem_write_q      <= mem_write_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            resp_valid_q     <= resp_valid_d;
            resp_fault_q     <= resp_fault_d;
            resp_ppn_q       <= resp_ppn_d;
            resp_superpage_q <= resp_superpage_d;
            resp_pte_q       <= resp_pte_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_fault     = resp_fault_q;
    assign bus.resp_ppn       = resp_ppn_q;
    assign bus.resp_superpage = resp_superpage_q;
    assign bus.resp_pte       = resp_pte_q;

endmodule

// File: tb/tb_sv32_page_table_walker.sv
// Bench for sv32_page_table_walker: directed page-table scenarios plus random
// walks against a behavioural Sv32 translation model and a sparse memory.
module tb_sv32_page_table_walker;

    logic clk;
    logic rst;
    sv32_page_table_walker_if bus();

    sv32_page_table_walker dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [logic [33:0]];
    int          mem_delay;
    logic        stray;
    int          wr_count;
    int          unstable_cnt;
    logic [33:0] last_wr_addr;
    logic [31:0] last_wr_data;

    int          n_cmp;
    int          n_fail;

    int          obs_cycle;
    int          obs_pulses;
    logic        obs_fault;
    logic        obs_sp;
    logic [21:0] obs_ppn;
    logic [31:0] obs_pte;
    logic        obs_ready_at_done;
    logic        obs_ready_after;

    logic        e_fault;
    logic        e_sp;
    logic [21:0] e_ppn;
    logic [31:0] e_pte;
    int          e_cycle;
    int          e_writes;
    logic [33:0] e_wr_addr;
    logic [31:0] e_wr_data;

    function automatic logic [31:0] rd(input logic [33:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Memory: answers each request after mem_delay extra cycles, tracks writes
    // and any change of the request fields while a request is pending.
    initial begin : responder
        logic        prev;
        logic        busy;
        int          cnt;
        logic [33:0] a0;
        logic        w0;
        logic [31:0] d0;
        busy = 1'b0;
        cnt  = 0;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            prev          = bus.mem_done;
            bus.mem_done  = 1'b0;
            bus.mem_rdata = $urandom;
            if (stray) begin
                stray        = 1'b0;
                bus.mem_done = 1'b1;
            end else if (rst || !bus.mem_req) begin
                busy = 1'b0;
            end else begin
                if (prev || !busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    a0   = bus.mem_addr;
                    w0   = bus.mem_write;
                    d0   = bus.mem_wdata;
                end else if (bus.mem_addr !== a0 || bus.mem_write !== w0 ||
                             (w0 && bus.mem_wdata !== d0)) begin
                    unstable_cnt++;
                end
                if (cnt >= mem_delay) begin
                    bus.mem_done = 1'b1;
                    if (bus.mem_write) begin
                        mem[bus.mem_addr] = bus.mem_wdata;
                        wr_count++;
                        last_wr_addr = bus.mem_addr;
                        last_wr_data = bus.mem_wdata;
                    end else begin
                        bus.mem_rdata = rd(bus.mem_addr);
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Sv32 translation as the privileged architecture states it, level by level.
    task automatic model_walk(input logic [21:0] sppn, input logic [19:0] vpn,
                              input logic [1:0] acc, input logic usr,
                              input logic mxr, input logic sum);
        logic [33:0] a;
        logic [31:0] pte;
        logic [31:0] upd;
        int          lvl;
        int          accesses;
        logic        leaf;
        logic        ok;
        a = {sppn, vpn[19:10], 2'b00};
        accesses = 0;
        leaf = 1'b0;
        e_fault = 1'b0;
        e_sp = 1'b0;
        e_ppn = '0;
        e_writes = 0;
        e_wr_addr = '0;
        e_wr_data = '0;
        pte = '0;
        for (lvl = 1; lvl >= 0; lvl--) begin
            pte = rd(a);
            accesses++;
            if (!pte[0] || (pte[2] && !pte[1])) begin
                e_fault = 1'b1;
                break;
            end
            if (pte[1] || pte[3]) begin
                leaf = 1'b1;
                break;
            end
            if (lvl == 0) begin
                e_fault = 1'b1;
                break;
            end
            a = {pte[31:10], vpn[9:0], 2'b00};
        end
        if (leaf && lvl == 1 && pte[19:10] != 10'd0) e_fault = 1'b1;
        if (leaf && !e_fault) begin
            ok = (acc == 2'd0) ? (pte[1] || (mxr && pte[3])) :
                 (acc == 2'd1) ? pte[2] : pte[3];
            if (usr) ok = ok && pte[4];
            else if (pte[4]) ok = ok && sum && (acc != 2'd2);
            if (!ok) e_fault = 1'b1;
        end
        e_pte = pte;
        if (!e_fault) begin
            upd = pte | 32'h40 | ((acc == 2'd1) ? 32'h80 : 32'h0);
            if (upd != pte) begin
                accesses++;
                e_writes = 1;
                e_wr_addr = a;
                e_wr_data = upd;
            end
            e_pte = upd;
            e_sp  = (lvl == 1);
            e_ppn = (lvl == 1) ? {pte[31:20], vpn[9:0]} : pte[31:10];
        end
        e_cycle = accesses * (mem_delay + 1) + 1;
    endtask

    task automatic run_walk(input logic [21:0] sppn, input logic [19:0] vpn,
                            input logic [1:0] acc, input logic usr,
                            input logic mxr, input logic sum);
        obs_cycle = -1;
        obs_pulses = 0;
        obs_ready_at_done = 1'bx;
        obs_ready_after = 1'b0;
        wr_count = 0;
        unstable_cnt = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_vpn    = vpn;
        bus.req_access = acc;
        bus.req_user   = usr;
        bus.csr_satp   = {1'b1, 9'h0, sppn};
        bus.csr_mxr    = mxr;
        bus.csr_sum    = sum;
        for (int w = 0; w < 20 && !bus.req_ready; w++) @(negedge clk);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.req_valid  = 1'b0;
                bus.req_vpn    = 20'($urandom);
                bus.req_access = 2'($urandom_range(0, 2));
                bus.req_user   = 1'($urandom);
                bus.csr_satp   = $urandom;
                bus.csr_mxr    = 1'($urandom);
                bus.csr_sum    = 1'($urandom);
            end
            if (bus.resp_valid) begin
                obs_pulses++;
                if (obs_cycle < 0) begin
                    obs_cycle = c;
                    obs_fault = bus.resp_fault;
                    obs_sp    = bus.resp_superpage;
                    obs_ppn   = bus.resp_ppn;
                    obs_pte   = bus.resp_pte;
                    obs_ready_at_done = bus.req_ready;
                end
            end else if (obs_cycle > 0) begin
                obs_ready_after = bus.req_ready;
                break;
            end
        end
    endtask

    task automatic setup_4k(input logic [31:0] leaf);
        mem.delete();
        mem[34'h80120] = 32'h00020401;
        mem[34'h81D14] = leaf;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset.req_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset.mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset.resp_valid: got %b want 0", bus.resp_valid); end
        n_cmp++; if ({bus.mem_write, bus.mem_addr, bus.mem_wdata} !== '0) begin n_fail++; $display("FAIL reset.mem_bus: got %b/%h/%h want 0", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        n_cmp++; if ({bus.resp_fault, bus.resp_superpage, bus.resp_ppn, bus.resp_pte} !== '0) begin n_fail++; $display("FAIL reset.resp_bus: got %b/%b/%h/%h want 0", bus.resp_fault, bus.resp_superpage, bus.resp_ppn, bus.resp_pte); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset.idle_after_release: got ready=%b req=%b want 1/0", bus.req_ready, bus.mem_req); end
    endtask

    task automatic test_read_hit;
        mem_delay = 0;
        setup_4k(32'h00048CC7);
        run_walk(22'h00080, 20'h12345, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_cycle !== 3) begin n_fail++; $display("FAIL read_hit.cycle: got %0d want 3", obs_cycle); end
        n_cmp++; if (obs_fault !== 1'b0 || obs_ppn !== 22'h00123) begin n_fail++; $display("FAIL read_hit.ppn: got fault=%b ppn=%h want 0/00123", obs_fault, obs_ppn); end
        n_cmp++; if (wr_count !== 0) begin n_fail++; $display("FAIL read_hit.writes: got %0d want 0", wr_count); end
        n_cmp++; if (obs_sp !== 1'b0 || obs_pte !== 32'h00048CC7) begin n_fail++; $display("FAIL read_hit.pte: got sp=%b pte=%h want 0/00048cc7", obs_sp, obs_pte); end
    endtask

    task automatic test_write_update;
        mem_delay = 0;
        setup_4k(32'h00048C07);
        run_walk(22'h00080, 20'h12345, 2'd1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (wr_count !== 1 || last_wr_addr !== 34'h81D14 || last_wr_data !== 32'h00048CC7) begin n_fail++; $display("FAIL write_update.mem_write: got n=%0d addr=%h data=%h want 1/81d14/00048cc7", wr_count, last_wr_addr, last_wr_data); end
        n_cmp++; if (obs_cycle !== 4) begin n_fail++; $display("FAIL write_update.cycle: got %0d want 4", obs_cycle); end
        n_cmp++; if (obs_pte !== 32'h00048CC7 || obs_fault !== 1'b0) begin n_fail++; $display("FAIL write_update.resp_pte: got pte=%h fault=%b want 00048cc7/0", obs_pte, obs_fault); end
    endtask

    task automatic test_superpage;
        mem_delay = 0;
        mem.delete();
        mem[34'h80120] = 32'h0010004B;
        run_walk(22'h00080, 20'h12345, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_sp !== 1'b1 || obs_ppn !== 22'h00745 || obs_fault !== 1'b0) begin n_fail++; $display("FAIL superpage.hit: got sp=%b ppn=%h fault=%b want 1/00745/0", obs_sp, obs_ppn, obs_fault); end
        n_cmp++; if (obs_cycle !== 2) begin n_fail++; $display("FAIL superpage.cycle: got %0d want 2", obs_cycle); end
        mem[34'h80120] = 32'h0010044B;
        run_walk(22'h00080, 20'h12345, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_fault !== 1'b1 || obs_ppn !== 22'h0 || obs_pte !== 32'h0010044B) begin n_fail++; $display("FAIL superpage.misaligned: got fault=%b ppn=%h pte=%h want 1/0/0010044b", obs_fault, obs_ppn, obs_pte); end
        n_cmp++; if (obs_cycle !== 2 || wr_count !== 0) begin n_fail++; $display("FAIL superpage.fault_timing: got cycle=%0d writes=%0d want 2/0", obs_cycle, wr_count); end
    endtask

    task automatic test_perm_fault;
        mem_delay = 0;
        setup_4k(32'h00048C43);
        run_walk(22'h00080, 20'h12345, 2'd1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_fault !== 1'b1 || wr_count !== 0) begin n_fail++; $display("FAIL perm.write_ro: got fault=%b writes=%0d want 1/0", obs_fault, wr_count); end
        run_walk(22'h00080, 20'h12345, 2'd0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (obs_fault !== 1'b1) begin n_fail++; $display("FAIL perm.user_on_s_page: got fault=%b want 1", obs_fault); end
        setup_4k(32'h00048C53);
        run_walk(22'h00080, 20'h12345, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_fault !== 1'b1) begin n_fail++; $display("FAIL perm.s_on_u_sum0: got fault=%b want 1", obs_fault); end
        run_walk(22'h00080, 20'h12345, 2'd0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (obs_fault !== 1'b0 || obs_ppn !== 22'h00123) begin n_fail++; $display("FAIL perm.s_on_u_sum1: got fault=%b ppn=%h want 0/00123", obs_fault, obs_ppn); end
    endtask

    task automatic test_wait_states;
        mem_delay = 3;
        setup_4k(32'h00048CC7);
        run_walk(22'h00080, 20'h12345, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_cycle !== 9) begin n_fail++; $display("FAIL wait.cycle: got %0d want 9", obs_cycle); end
        n_cmp++; if (unstable_cnt !== 0) begin n_fail++; $display("FAIL wait.addr_stable: got %0d changes want 0", unstable_cnt); end
        n_cmp++; if (obs_ppn !== 22'h00123 || obs_fault !== 1'b0) begin n_fail++; $display("FAIL wait.ppn: got %h fault=%b want 00123/0", obs_ppn, obs_fault); end
        mem_delay = 0;
    endtask

    task automatic test_reset_mid_walk;
        logic seen;
        mem_delay = 5;
        setup_4k(32'h00048CC7);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_vpn    = 20'h12345;
        bus.req_access = 2'd0;
        bus.req_user   = 1'b0;
        bus.csr_satp   = 32'h80000080;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.mem_req && bus.mem_addr == 34'h81D14) break;
            @(negedge clk);
        end
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 34'h81D14) begin n_fail++; $display("FAIL rst_mid.reach_l0: got req=%b addr=%h want 1/81d14", bus.mem_req, bus.mem_addr); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid.mem_req_async: got %b want 0", bus.mem_req); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stray = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_req) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid.no_activity: got %b want 0", seen); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid.ready: got %b want 1", bus.req_ready); end
        mem_delay = 0;
        run_walk(22'h00080, 20'h12345, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_cycle !== 3 || obs_ppn !== 22'h00123 || obs_fault !== 1'b0) begin n_fail++; $display("FAIL rst_mid.fresh_walk: got cycle=%0d ppn=%h fault=%b want 3/00123/0", obs_cycle, obs_ppn, obs_fault); end
    endtask

    task automatic test_back_to_back;
        mem_delay = 0;
        setup_4k(32'h00048CC7);
        for (int i = 0; i < 2; i++) begin
            run_walk(22'h00080, 20'h12345, 2'd0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (obs_pulses !== 1) begin n_fail++; $display("FAIL b2b.pulse_width: got %0d want 1", obs_pulses); end
            n_cmp++; if (obs_ready_at_done !== 1'b0 || obs_ready_after !== 1'b1) begin n_fail++; $display("FAIL b2b.ready: got done=%b after=%b want 0/1", obs_ready_at_done, obs_ready_after); end
        end
    endtask

    task automatic test_random;
        logic [21:0] sppn;
        logic [19:0] vpn;
        logic [1:0]  acc;
        logic        usr, mxr, sum;
        logic [31:0] l1;
        logic [31:0] l0;
        int          kind;
        for (int it = 0; it < 60; it++) begin
            mem.delete();
            sppn = 22'($urandom);
            vpn  = 20'($urandom);
            acc  = 2'($urandom_range(0, 2));
            usr  = 1'($urandom);
            mxr  = 1'($urandom);
            sum  = 1'($urandom);
            kind = $urandom_range(0, 3);
            l1 = $urandom;
            l1[0] = ($urandom_range(0, 7) != 0);
            if (kind < 2) begin
                l1[3:1] = 3'b000;
                l0 = $urandom;
                l0[0] = ($urandom_range(0, 7) != 0);
                mem[{l1[31:10], vpn[9:0], 2'b00}] = l0;
            end else if (kind == 2 && $urandom_range(0, 3) != 0) begin
                l1[19:10] = 10'd0;
            end
            mem[{sppn, vpn[19:10], 2'b00}] = l1;
            mem_delay = $urandom_range(0, 2);
            model_walk(sppn, vpn, acc, usr, mxr, sum);
            run_walk(sppn, vpn, acc, usr, mxr, sum);
            n_cmp++; if (obs_fault !== e_fault || obs_pte !== e_pte) begin n_fail++; $display("FAIL rand[%0d].fault_pte: got %b/%h want %b/%h", it, obs_fault, obs_pte, e_fault, e_pte); end
            n_cmp++; if (obs_ppn !== e_ppn || (!e_fault && obs_sp !== e_sp)) begin n_fail++; $display("FAIL rand[%0d].ppn: got %h sp=%b want %h sp=%b", it, obs_ppn, obs_sp, e_ppn, e_sp); end
            n_cmp++; if (obs_cycle !== e_cycle) begin n_fail++; $display("FAIL rand[%0d].cycle: got %0d want %0d", it, obs_cycle, e_cycle); end
            n_cmp++; if (wr_count !== e_writes || (e_writes == 1 && (last_wr_addr !== e_wr_addr || last_wr_data !== e_wr_data))) begin n_fail++; $display("FAIL rand[%0d].writeback: got n=%0d %h<=%h want n=%0d %h<=%h", it, wr_count, last_wr_addr, last_wr_data, e_writes, e_wr_addr, e_wr_data); end
        end
        mem_delay = 0;
    endtask

    initial begin
        rst = 1'b1;
        n_cmp = 0;
        n_fail = 0;
        stray = 1'b0;
        mem_delay = 0;
        wr_count = 0;
        unstable_cnt = 0;
        last_wr_addr = '0;
        last_wr_data = '0;
        bus.req_valid = 1'b0;
        bus.req_vpn = '0;
        bus.req_access = 2'd0;
        bus.req_user = 1'b0;
        bus.csr_satp = '0;
        bus.csr_mxr = 1'b0;
        bus.csr_sum = 1'b0;
        test_reset;
        test_read_hit;
        test_write_update;
        test_superpage;
        test_perm_fault;
        test_wait_states;
        test_reset_mid_walk;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
